// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction prefetch queue.
package instr_fetch_pkg;

    typedef enum logic [1:0] {
        StRun,
        StWait,
        StDiscard,
        StFault
    } fetch_state_e;

    localparam int unsigned WORD_BYTES    = 8;
    localparam int unsigned MAX_INSTR_LEN = 10;

    // Bytes still usable in a word when fetching from byte lane 'off' onward.
    function automatic logic [3:0] lane_need(input logic [2:0] off);
        return 4'(WORD_BYTES) - {1'b0, off};
    endfunction

endpackage

// File: rtl/byte_ring.sv
// Byte ring for the prefetch queue: tail write of up to one word, window read at the head.
module byte_ring
    import instr_fetch_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned WINDOW = MAX_INSTR_LEN
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [$clog2(DEPTH):0]    count,
    input  logic [$clog2(DEPTH)-1:0]  adv,
    input  logic                      wr_en,
    input  logic [2:0]                wr_off,
    input  logic [8*WORD_BYTES-1:0]   wr_data,
    output logic [8*WINDOW-1:0]       win
);
    localparam int unsigned IW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [IW-1:0] head_q;
    logic [IW-1:0] tail;

    // count == DEPTH wraps tail onto head, but a full ring is never written.
    assign tail = head_q + count[IW-1:0];

    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_q <= '0;
        end else begin
            head_q <= head_q + adv;
        end
    end

    always_ff @(negedge clock) begin
        if (wr_en) begin
            for (int j = 0; j < WORD_BYTES; j++) begin
                if (j >= int'(wr_off)) begin
                    mem_q[tail + IW'(j) - IW'(wr_off)] <= wr_data[8*j +: 8];
                end
            end
        end
    end

    always_comb begin
        win = '0;
        for (int i = 0; i < WINDOW; i++) begin
            if (i < int'(count)) begin
                win[8*i +: 8] = mem_q[head_q + IW'(i)];
            end
        end
    end

endmodule

// File: rtl/instr_prefetch.sv
// Instruction prefetch queue feeding the decoder with a window at the current IP.
// Optional PREFETCH_STATS_EN adds saturating fetch/flush counters.
module instr_prefetch
    import instr_fetch_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned WINDOW = MAX_INSTR_LEN
) (
    input  logic                  clock,
    input  logic                  reset_n,
    output logic                  mem_req,
    output logic [63:0]           mem_addr,
    input  logic                  mem_ack,
    input  logic [63:0]           mem_data,
    input  logic                  mem_err,
    output logic [8*WINDOW-1:0]   win_bytes,
    output logic [4:0]            win_len,
    output logic [63:0]           win_ip,
    input  logic [3:0]            consume,
    input  logic                  redirect,
    input  logic [63:0]           redirect_ip,
    input  logic                  inval,
    input  logic [63:0]           inval_addr,
    output logic                  fault
`ifdef PREFETCH_STATS_EN
    ,
    output logic [31:0]           stat_fetch,
    output logic [31:0]           stat_flush
`endif
);
    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned CW = IW + 1;

    fetch_state_e  state_q, state_d;
    logic [63:0]   ip_q, ip_d;
    logic [CW-1:0] count_q, count_d;
    logic          req_q, req_d;
    logic [63:0]   addr_q, addr_d;

    logic [63:0]   fetch_addr, next_fetch;
    logic [3:0]    need;
    logic [CW-1:0] retire;
    logic          active, inval_hit, flush, ack_ok, wr_en, idle;
    logic [IW-1:0] adv;

    assign fetch_addr = ip_q + 64'(count_q);
    assign need       = lane_need(fetch_addr[2:0]);
    assign retire     = (CW'(consume) > count_q) ? count_q : CW'(consume);
    assign active     = (state_q != StFault);
    // While a word is in flight its bytes count as prefetched too.
    assign inval_hit  = active && inval && ((inval_addr | 64'h7) >= ip_q) &&
                        (inval_addr < fetch_addr + ((state_q == StWait) ? 64'(need) : 64'd0));
    assign flush      = active && (redirect || inval_hit);
    assign ack_ok     = (state_q == StWait) && mem_ack && !mem_err;
    assign wr_en      = ack_ok && !flush;
    assign adv        = active ? retire[IW-1:0] : '0;

    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StRun;
            ip_q    <= '0;
            count_q <= '0;
            req_q   <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            ip_q    <= ip_d;
            count_q <= count_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ip_d       = ip_q;
        count_d    = count_q;
        req_d      = req_q;
        addr_d     = addr_q;
        idle       = 1'b0;
        next_fetch = '0;
        unique case (state_q)
            StRun: begin
                ip_d    = ip_q + 64'(retire);
                count_d = count_q - retire;
                idle    = 1'b1;
            end
            StWait: begin
                ip_d    = ip_q + 64'(retire);
                count_d = count_q - retire;
                if (mem_ack && mem_err) begin
                    state_d = StFault;
                end else if (mem_ack) begin
                    count_d = count_q - retire + CW'(need);
                    idle    = 1'b1;
                end else if (flush) begin
                    state_d = StDiscard;
                end
            end
            StDiscard: begin
                ip_d    = ip_q + 64'(retire);
                count_d = count_q - retire;
                idle    = mem_ack;
            end
            StFault: ;
        endcase
        if (flush && state_d != StFault) begin
            count_d = '0;
            if (redirect) ip_d = redirect_ip;
        end
        // No request outstanding after this edge: issue the next one if it fits.
        if (idle) begin
            next_fetch = ip_d + 64'(count_d);
            if (32'(DEPTH) - 32'(count_d) >= 32'(lane_need(next_fetch[2:0]))) begin
                state_d = StWait;
                req_d   = 1'b1;
                addr_d  = {next_fetch[63:3], 3'b000};
            end else begin
                state_d = StRun;
                req_d   = 1'b0;
            end
        end
        if (state_d == StFault) req_d = 1'b0;
    end

    always_comb begin
        mem_req  = req_q;
        mem_addr = addr_q;
        win_ip   = ip_q;
        win_len  = 5'(count_q);
        fault    = (state_q == StFault);
    end

    byte_ring #(
        .DEPTH  (DEPTH),
        .WINDOW (WINDOW)
    ) u_ring (
        .clock   (clock),
        .reset_n (reset_n),
        .count   (count_q),
        .adv     (adv),
        .wr_en   (wr_en),
        .wr_off  (fetch_addr[2:0]),
        .wr_data (mem_data),
        .win     (win_bytes)
    );

    always_ff @(negedge clock) begin
        if (reset_n && active) begin
            assert (CW'(consume) <= count_q)
            else $error("instr_prefetch: consume %0d exceeds win_len %0d", consume, count_q);
        end
    end

`ifdef PREFETCH_STATS_EN
    logic [31:0] stat_fetch_q, stat_flush_q;

    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stat_fetch_q <= '0;
            stat_flush_q <= '0;
        end else begin
            if (wr_en && stat_fetch_q != '1) stat_fetch_q <= stat_fetch_q + 32'd1;
            if (flush && stat_flush_q != '1) stat_flush_q <= stat_flush_q + 32'd1;
        end
    end

    assign stat_fetch = stat_fetch_q;
    assign stat_flush = stat_flush_q;
`endif

endmodule
